// File: rtl/mem_burst_loader.sv
// mem_burst_loader
//   Copies a program image from a synchronous image ROM into memory using
//   burst writes, then optionally reads the region back and compares it
//   word-for-word against the ROM.
//
//   State | Meaning
//   ------+-----------------------------------------------------------
//   IDLE     | waiting for start; results of the last run are held
//   WAIT_MEM | between bursts; waits for mem_busy low, sizes next burst
//   PREFETCH | one cycle of ROM latency before the first beat
//   WR_BURST | write beats, one ROM word per cycle
//   RD_BURST | read beats; comparison trails each beat by one cycle
//   RD_DRAIN | last comparison of a read burst
//   FINISH   | done pulse is registered, busy drops
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, verify_en    one-cycle request and readback enable (IDLE only)
//   word_count          image length in 32-bit words, sampled with start
//   src_addr, src_data  ROM word index / data (data one cycle after index)
//   mem_addr            burst base byte address, held for the whole burst
//   mem_din, mem_dout   write data per beat / read data one cycle after beat
//   mem_access_size     00=1, 01=4, 10=8, 11=16 words
//   mem_rw, mem_enable  1=write / beat strobe
//   mem_busy            no burst may start while high
//   busy, done, pass    run status; pass valid from done until next start
//   mismatch_count      saturating count of miscompared words
//   first_bad_addr      byte address of the first miscompare, 0 if none
module mem_burst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
  parameter int          CNT_W     = 10,
  parameter int          MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             verify_en,
  input  logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] src_addr,
  input  logic [31:0]      src_data,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout,
  output logic [1:0]       mem_access_size,
  output logic             mem_rw,
  output logic             mem_enable,
  input  logic             mem_busy,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [31:0]      first_bad_addr
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_MEM = 3'd1,
    PREFETCH = 3'd2,
    WR_BURST = 3'd3,
    RD_BURST = 3'd4,
    RD_DRAIN = 3'd5,
    FINISH   = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             phase_rd;
  logic             verify_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] index_q;
  logic [4:0]       size_q;
  logic [3:0]       beat_cnt;

  logic [CNT_W-1:0] remaining;
  logic [31:0]      rem_ext;
  logic [CNT_W-1:0] index_adv;
  logic [CNT_W-1:0] beat_word;
  logic [4:0]       sel_size;
  logic [1:0]       sel_code;
  logic             last_beat;
  logic             phase_end;
  logic [31:0]      index_byte_addr;
  logic [31:0]      beat_byte_addr;

  logic [31:0]      src_q;
  logic             cmp_valid_q;
  logic [31:0]      cmp_addr_q;
  logic             miscompare;

  assign remaining = total_q - index_q;
  assign rem_ext   = 32'(remaining);
  assign index_adv = index_q + CNT_W'(size_q);
  assign phase_end = (index_adv == total_q);
  assign last_beat = (beat_cnt == 4'd0);

  // src_addr runs one word ahead of the beat, so the word on the bus is
  // the one before it.
  assign beat_word = src_addr - CNT_W'(1);

  assign index_byte_addr = BASE_ADDR + (32'(index_q) << 2);
  assign beat_byte_addr  = BASE_ADDR + (32'(beat_word) << 2);

  assign miscompare = cmp_valid_q && (mem_dout != src_q);

  // Largest legal burst that fits both the remaining words and MAX_BURST.
  always_comb begin
    sel_size = 5'd1;
    sel_code = 2'b00;
    if ((MAX_BURST >= 16) && (rem_ext >= 32'd16)) begin
      sel_size = 5'd16;
      sel_code = 2'b11;
    end else if ((MAX_BURST >= 8) && (rem_ext >= 32'd8)) begin
      sel_size = 5'd8;
      sel_code = 2'b10;
    end else if ((MAX_BURST >= 4) && (rem_ext >= 32'd4)) begin
      sel_size = 5'd4;
      sel_code = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_enable = 1'b0;
    mem_rw     = 1'b1;
    mem_din    = 32'h0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? FINISH : WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (!mem_busy) begin
          state_nxt = PREFETCH;
        end
      end
      PREFETCH: begin
        state_nxt = phase_rd ? RD_BURST : WR_BURST;
      end
      WR_BURST: begin
        mem_enable = 1'b1;
        mem_din    = src_data;
        if (last_beat) begin
          if (!phase_end || verify_q) begin
            state_nxt = WAIT_MEM;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      RD_BURST: begin
        mem_enable = 1'b1;
        mem_rw     = 1'b0;
        if (last_beat) begin
          state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        state_nxt = (index_q != total_q) ? WAIT_MEM : FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Readback pipeline: ROM word and its byte address are delayed one stage
  // to line up with mem_dout, which arrives the cycle after each read beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q       <= 32'h0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= 32'h0;
    end else begin
      src_q       <= src_data;
      cmp_valid_q <= (state == RD_BURST);
      cmp_addr_q  <= beat_byte_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_rd        <= 1'b0;
      verify_q        <= 1'b0;
      total_q         <= '0;
      index_q         <= '0;
      size_q          <= 5'd1;
      beat_cnt        <= 4'd0;
      src_addr        <= '0;
      mem_addr        <= BASE_ADDR;
      mem_access_size <= 2'b11;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b1;
      mismatch_count  <= '0;
      first_bad_addr  <= 32'h0;
    end else begin
      done <= 1'b0;

      if (miscompare) begin
        pass <= 1'b0;
        if (mismatch_count != '1) begin
          mismatch_count <= mismatch_count + CNT_W'(1);
        end
        if (mismatch_count == '0) begin
          first_bad_addr <= cmp_addr_q;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            total_q        <= word_count;
            verify_q       <= verify_en;
            phase_rd       <= 1'b0;
            index_q        <= '0;
            mismatch_count <= '0;
            first_bad_addr <= 32'h0;
            pass           <= 1'b1;
            busy           <= 1'b1;
          end
        end
        WAIT_MEM: begin
          if (!mem_busy) begin
            size_q          <= sel_size;
            mem_access_size <= sel_code;
            beat_cnt        <= 4'(sel_size - 5'd1);
            mem_addr        <= index_byte_addr;
            src_addr        <= index_q;
          end
        end
        PREFETCH: begin
          src_addr <= src_addr + CNT_W'(1);
        end
        WR_BURST: begin
          src_addr <= src_addr + CNT_W'(1);
          if (last_beat) begin
            if (phase_end && verify_q) begin
              phase_rd <= 1'b1;
              index_q  <= '0;
            end else begin
              index_q <= index_adv;
            end
          end else begin
            beat_cnt <= beat_cnt - 4'd1;
          end
        end
        RD_BURST: begin
          src_addr <= src_addr + CNT_W'(1);
          if (last_beat) begin
            index_q <= index_adv;
          end else begin
            beat_cnt <= beat_cnt - 4'd1;
          end
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_loader.sv
module tb_mem_burst_loader;

  localparam logic [31:0] BASE = 32'h8002_0000;
  localparam int          CW   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start16 = 1'b0;
  logic          start4  = 1'b0;
  logic          verify  = 1'b0;
  logic [CW-1:0] wc      = '0;
  logic          sel     = 1'b0;

  logic [CW-1:0] src_addr16, src_addr4;
  logic [31:0]   src_data16 = 32'h0;
  logic [31:0]   src_data4  = 32'h0;
  logic [31:0]   mem_addr16, mem_addr4, mem_din16, mem_din4;
  logic [1:0]    size16, size4;
  logic          rw16, rw4, en16, en4, busy16, busy4;
  logic          done16, done4, pass16, pass4;
  logic [CW-1:0] mis16, mis4;
  logic [31:0]   fb16, fb4;
  logic [31:0]   mem_dout = 32'h0;
  logic          mem_busy;

  mem_burst_loader #(.BASE_ADDR(BASE), .CNT_W(CW), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start16), .verify_en(verify),
    .word_count(wc), .src_addr(src_addr16), .src_data(src_data16),
    .mem_addr(mem_addr16), .mem_din(mem_din16), .mem_dout(mem_dout),
    .mem_access_size(size16), .mem_rw(rw16), .mem_enable(en16),
    .mem_busy(mem_busy), .busy(busy16), .done(done16), .pass(pass16),
    .mismatch_count(mis16), .first_bad_addr(fb16)
  );

  mem_burst_loader #(.BASE_ADDR(BASE), .CNT_W(CW), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .verify_en(verify),
    .word_count(wc), .src_addr(src_addr4), .src_data(src_data4),
    .mem_addr(mem_addr4), .mem_din(mem_din4), .mem_dout(mem_dout),
    .mem_access_size(size4), .mem_rw(rw4), .mem_enable(en4),
    .mem_busy(mem_busy), .busy(busy4), .done(done4), .pass(pass4),
    .mismatch_count(mis4), .first_bad_addr(fb4)
  );

  // Shared memory model sees whichever loader is selected.
  logic          m_en, m_rw, m_busy_o, m_done, m_pass;
  logic [31:0]   m_addr, m_din, m_fb;
  logic [1:0]    m_size;
  logic [CW-1:0] m_mis, m_src;
  assign m_en     = sel ? en4       : en16;
  assign m_rw     = sel ? rw4       : rw16;
  assign m_addr   = sel ? mem_addr4 : mem_addr16;
  assign m_din    = sel ? mem_din4  : mem_din16;
  assign m_size   = sel ? size4     : size16;
  assign m_busy_o = sel ? busy4     : busy16;
  assign m_done   = sel ? done4     : done16;
  assign m_pass   = sel ? pass4     : pass16;
  assign m_mis    = sel ? mis4      : mis16;
  assign m_fb     = sel ? fb4       : fb16;
  assign m_src    = sel ? src_addr4 : src_addr16;

  int img_seed = 0;

  function automatic logic [31:0] rom_word(input int seed, input int i);
    return 32'hC0DE_0000 ^ (32'(seed) << 24) ^ (32'(i) * 32'h0001_0003);
  endfunction

  always @(posedge clk) src_data16 <= rom_word(img_seed, int'(src_addr16));
  always @(posedge clk) src_data4  <= rom_word(img_seed, int'(src_addr4));

  function automatic int size_of(input logic [1:0] c);
    case (c)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  logic [31:0] mem_arr [0:1023];
  int   mdl_k     = 0;
  int   busy_cnt  = 0;
  int   stall_len = 0;
  logic corrupt   = 1'b0;
  int   mdl_w;

  assign mdl_w    = int'((m_addr - BASE) >> 2) + mdl_k;
  assign mem_busy = (busy_cnt != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_k    <= 0;
      busy_cnt <= 0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (m_en) begin
        if (mdl_k + 1 == size_of(m_size)) begin
          mdl_k <= 0;
          if (stall_len != 0) busy_cnt <= stall_len;
        end else begin
          mdl_k <= mdl_k + 1;
        end
        if (mdl_w >= 0 && mdl_w < 1024) begin
          if (m_rw) mem_arr[mdl_w[9:0]] <= m_din;
          else mem_dout <= mem_arr[mdl_w[9:0]] ^
                           ((corrupt && (mdl_w == 3 || mdl_w == 40)) ? 32'hFFFF_0000 : 32'h0);
        end
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  code;
    logic        rw;
    int          len;
  } burst_t;

  burst_t exp_q[$];
  burst_t cur;
  int checks      = 0;
  int failures    = 0;
  int run         = 0;
  int done_cnt    = 0;
  int beats_total = 0;
  int busy_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_b(input logic [31:0] a, input logic [1:0] c, input logic rw, input int len);
    exp_q.push_back('{addr: a, code: c, rw: rw, len: len});
  endtask

  task automatic push_46(input logic rw);
    push_b(32'h8002_0000, 2'b11, rw, 16);
    push_b(32'h8002_0040, 2'b11, rw, 16);
    push_b(32'h8002_0080, 2'b10, rw, 8);
    push_b(32'h8002_00A0, 2'b01, rw, 4);
    push_b(32'h8002_00B0, 2'b00, rw, 1);
    push_b(32'h8002_00B4, 2'b00, rw, 1);
  endtask

  task automatic pulse_start(input int n, input logic ver);
    @(negedge clk);
    wc     = CW'(n);
    verify = ver;
    if (sel) start4 = 1'b1;
    else start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    start4  = 1'b0;
  endtask

  task automatic chk_mem(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (mem_arr[i] !== rom_word(img_seed, i)) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic run_load(input string tag, input int n, input logic ver, input int exp_mis,
                          input logic exp_pass, input logic [31:0] exp_fb);
    int d0  = done_cnt;
    int cyc = 0;
    img_seed++;
    pulse_start(n, ver);
    chk({tag, "_busy_high"}, 32'(m_busy_o), 32'd1);
    while (m_done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(m_done === 1'b1), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_low"}, 32'(m_busy_o), 32'd0);
    chk({tag, "_pass"}, 32'(m_pass), 32'(exp_pass));
    chk({tag, "_mismatch_count"}, 32'(m_mis), 32'(exp_mis));
    chk({tag, "_first_bad_addr"}, m_fb, exp_fb);
    chk({tag, "_bursts_left"}, 32'(exp_q.size()), 32'd0);
    chk_mem({tag, "_mem_image"}, n);
  endtask

  initial begin
    int b0;
    int s0;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          run = 0;
        end else begin
          if (m_en) begin
            beats_total++;
            if (run == 0) begin
              chk("burst_expected", 32'(exp_q.size() != 0), 32'd1);
              if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                chk("burst_addr", m_addr, cur.addr);
                chk("burst_size", 32'(m_size), 32'(cur.code));
                chk("burst_rw", 32'(m_rw), 32'(cur.rw));
              end else begin
                cur = '{addr: m_addr, code: m_size, rw: m_rw, len: 0};
              end
            end else begin
              chk("addr_hold", m_addr, cur.addr);
            end
            run++;
          end else if (run != 0) begin
            chk("burst_len", 32'(run), 32'(cur.len));
            run = 0;
          end
          if (mem_busy) begin
            busy_cycles++;
            chk("en_while_busy", 32'(m_en), 32'd0);
          end
          if (m_done) done_cnt++;
        end
      end
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_enable", 32'(m_en), 32'd0);
    chk("rst_rw", 32'(m_rw), 32'd1);
    chk("rst_size", 32'(m_size), 32'd3);
    chk("rst_addr", m_addr, BASE);
    chk("rst_din", m_din, 32'd0);
    chk("rst_src_addr", 32'(m_src), 32'd0);
    chk("rst_busy", 32'(m_busy_o), 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_pass", 32'(m_pass), 32'd1);
    chk("rst_mismatch", 32'(m_mis), 32'd0);
    chk("rst_first_bad", m_fb, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 46 words, load and verify, faithful memory
    push_46(1'b1);
    push_46(1'b0);
    run_load("clean", 46, 1'b1, 0, 1'b1, 32'h0);

    // Memory corrupts words 3 and 40 on readback
    corrupt = 1'b1;
    push_46(1'b1);
    push_46(1'b0);
    run_load("corrupt", 46, 1'b1, 2, 1'b0, 32'h8002_000C);
    corrupt = 1'b0;

    // Memory busy for 5 cycles after every burst
    stall_len = 5;
    s0 = busy_cycles;
    push_46(1'b1);
    push_46(1'b0);
    run_load("stall", 46, 1'b1, 0, 1'b1, 32'h0);
    chk("stall_busy_cycles", 32'(busy_cycles - s0), 32'd60);
    stall_len = 0;

    // Zero-length image
    b0 = beats_total;
    pulse_start(0, 1'b1);
    chk("zero_done_early", 32'(m_done), 32'd0);
    chk("zero_busy_early", 32'(m_busy_o), 32'd1);
    @(negedge clk);
    chk("zero_done", 32'(m_done), 32'd1);
    chk("zero_busy_low", 32'(m_busy_o), 32'd0);
    chk("zero_pass", 32'(m_pass), 32'd1);
    @(negedge clk);
    chk("zero_done_single", 32'(m_done), 32'd0);
    chk("zero_no_beats", 32'(beats_total - b0), 32'd0);

    // Reset during the 8th beat of the second burst
    exp_q.delete();
    push_46(1'b1);
    img_seed++;
    pulse_start(46, 1'b0);
    repeat (27) @(posedge clk);
    #2;
    chk("abort_in_beat", 32'(m_en), 32'd1);
    chk("abort_burst_addr", m_addr, 32'h8002_0040);
    chk("abort_beat_index", 32'(run), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("abort_enable_low", 32'(m_en), 32'd0);
    chk("abort_busy_low", 32'(m_busy_o), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    push_46(1'b1);
    push_46(1'b0);
    run_load("after_reset", 46, 1'b1, 0, 1'b1, 32'h0);

    // MAX_BURST=4 loader, 10 words, no verify
    sel = 1'b1;
    @(negedge clk);
    push_b(32'h8002_0000, 2'b01, 1'b1, 4);
    push_b(32'h8002_0010, 2'b01, 1'b1, 4);
    push_b(32'h8002_0020, 2'b00, 1'b1, 1);
    push_b(32'h8002_0024, 2'b00, 1'b1, 1);
    run_load("max4", 10, 1'b0, 0, 1'b1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_burst_loader.md
Name: mem_burst_loader

Overview:
- Sequential DMA engine that copies a program image from a synchronous image ROM into mips_memory2 using burst writes.
- Optionally reads the same region back and compares it word-for-word against the ROM.
- Replaces hand-rolled negedge loader loops. Sits between boot/test control and the memory port.
- Generalised in base address, image size, burst length and mode (load-only or load+verify).

Parameters:
- BASE_ADDR, 32'h8002_0000, byte address of image word 0 in memory.
- CNT_W, 10, width of word counts and ROM word index; max image is 2^CNT_W-1 words.
- MAX_BURST, 16, largest burst in words; legal values 1, 4, 8, 16.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- verify_en  in  1  sampled with start; 1 = readback compare after load.
- word_count  in  CNT_W  image length in 32-bit words; sampled with start.
- src_addr  out  CNT_W  ROM word index; ROM returns src_data one cycle later.
- src_data  in  32  ROM read data.
- mem_addr  out  32  burst base byte address, held for the whole burst.
- mem_din  out  32  write data, one word per beat.
- mem_dout  in  32  read data, valid the cycle after each read beat.
- mem_access_size  out  2  burst size: 00=1, 01=4, 10=8, 11=16 words.
- mem_rw  out  1  1 = write, 0 = read.
- mem_enable  out  1  beat strobe.
- mem_busy  in  1  memory busy; no new burst may start while high.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- pass  out  1  1 = verify clean or not run; valid from done until the next start.
- mismatch_count  out  CNT_W  number of miscompared words; saturates.
- first_bad_addr  out  32  byte address of the first mismatch; 0 if there was none.

Behaviour:
- Reset, asynchronous:
  - Outputs: mem_enable=0, mem_rw=1, mem_access_size=2'b11, mem_addr=BASE_ADDR, mem_din=0, src_addr=0, busy=0, done=0, pass=1, mismatch_count=0, first_bad_addr=0.
  - State returns to IDLE.
  - Reset mid-burst drops mem_enable immediately; the partial burst is abandoned.
- States: IDLE, WAIT_MEM, PREFETCH, WR_BURST, RD_BURST, RD_DRAIN, FINISH.
- IDLE:
  - On start: latch word_count and verify_en, clear mismatch_count and first_bad_addr, set pass=1, set busy=1.
  - If word_count==0, go to FINISH. Otherwise go to WAIT_MEM with phase=WRITE and index=0.
  - start outside IDLE is ignored.
- WAIT_MEM:
  - mem_enable=0; remain until mem_busy==0.
  - Then choose burst size = largest of {16,8,4,1} that is <= both remaining words and MAX_BURST.
  - Set mem_addr = BASE_ADDR + 4*index.
  - Drive src_addr=index and go to PREFETCH.
- PREFETCH:
  - One cycle for ROM latency.
  - Next state is WR_BURST when phase=WRITE, else RD_BURST.
- WR_BURST:
  - mem_enable=1, mem_rw=1 for exactly size consecutive cycles.
  - Beat k drives mem_din = ROM word index+k; src_addr runs one word ahead.
  - After the last beat, index advances by size.
  - If words remain, go to WAIT_MEM.
  - Else, with verify latched, go to WAIT_MEM with phase=READ and index=0; otherwise go to FINISH.
- RD_BURST:
  - mem_enable=1, mem_rw=0 for size cycles.
  - Source data is delayed one stage so ROM word index+k is compared to mem_dout on the cycle after beat k.
  - Then go to RD_DRAIN for the final comparison.
  - From RD_DRAIN: go to WAIT_MEM if words remain, else FINISH.
- Compare:
  - On mismatch, mismatch_count increments (saturating at all-ones) and pass clears.
  - first_bad_addr is written only on the first mismatch.
- FINISH: done=1 for one cycle, busy=0, then return to IDLE. Results hold until the next start.
- mem_busy asserted mid-burst is ignored; it is checked only between bursts.
- Arithmetic:
  - Addresses are 32-bit and wrap modulo 2^32 without error.
  - Remaining count is computed in CNT_W bits.

Test Plan:
- 46-word image, verify_en=1, memory faithful:
  - Write bursts are 16,16,8,4,1,1 at 0x80020000, 0x80020040, 0x80020080, 0x800200A0, 0x800200B0, 0x800200B4 with access sizes 11,11,10,01,00,00.
  - The same sequence repeats with rw=0.
  - done is a single pulse; pass=1, mismatch_count=0.
- Same image, memory model corrupts words 3 and 40:
  - mismatch_count=2, pass=0, first_bad_addr=0x8002000C.
- mem_busy held high for 5 cycles after each burst:
  - mem_enable stays 0 while busy; no beats are lost; data is identical to the unstalled run.
- word_count=0 with start:
  - done pulses 2 cycles after start; no mem_enable ever; pass=1.
- rst_n pulsed low during the 8th beat of the second burst:
  - mem_enable=0 and busy=0 immediately.
  - A new start reloads from 0x80020000 correctly.
- MAX_BURST=4 with a 10-word image, verify_en=0:
  - Bursts are 4,4,1,1; no read phase; pass=1.
